// File: rtl/ntt_poly_loader_if.sv
// ---------------------------------------------------------------------------
// ntt_poly_loader_if
// Bundles the stream-in handshake, the bank write port and the status flags
// of the NTT polynomial loader.
//   master : drives start / in_valid / in_data, observes everything else
//   slave  : the loader itself
// Signals:
//   start       one-cycle pulse that begins a load
//   in_valid    in_data is valid
//   in_data     raw coefficient, 0..4095
//   in_ready    loader accepts in_data this cycle
//   bank_wen    one-hot bank write enable
//   bank_addr   row address inside the selected bank
//   bank_wdata  coefficient reduced modulo q
//   busy        load in progress (LOAD or DONE)
//   done        one-cycle completion pulse
//   range_err   sticky: some accepted input was >= q
// ---------------------------------------------------------------------------
interface ntt_poly_loader_if #(
  parameter int DATA_W = 12
);
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [3:0]        bank_wen;
  logic [6:0]        bank_addr;
  logic [DATA_W-1:0] bank_wdata;
  logic              busy;
  logic              done;
  logic              range_err;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, bank_wen, bank_addr, bank_wdata, busy, done, range_err
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, bank_wen, bank_addr, bank_wdata, busy, done, range_err
  );
endinterface

// File: rtl/ntt_poly_loader.sv
// ---------------------------------------------------------------------------
// ntt_poly_loader
// Upstream feeder for the 512-point NTT core. Accepts a 512-coefficient
// stream, reduces each coefficient modulo q = 3329 and writes it into one of
// four 128-row data banks using the core's conflict-free placement:
//   bank = (a[1:0] + a[3:2] + a[5:4] + a[7:6] + a[8]) mod 4,  row = a[8:2]
// Every accept in cycle t produces a registered bank write in cycle t+1.
//
// Optional feature: define LOAD_BITREV_EN to treat the incoming stream as
// bit-reversed (effective index a = 9-bit reversal of the running index).
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   bus  ntt_poly_loader_if.slave (handshake, bank write port, status)
// ---------------------------------------------------------------------------
module ntt_poly_loader #(
  parameter int N_COEFF = 512,
  parameter int Q_MOD   = 3329,
  parameter int DATA_W  = 12
) (
  input  logic             clk,
  input  logic             rst,
  ntt_poly_loader_if.slave bus
);

  localparam int                IDX_W    = 9;
  localparam int                ROW_W    = 7;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_COEFF - 1);
  localparam logic [DATA_W-1:0] Q_VAL    = DATA_W'(Q_MOD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Effective placement index; reversal wiring only exists when enabled.
  function automatic logic [IDX_W-1:0] eff_index(input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] a;
`ifdef LOAD_BITREV_EN
    for (int k = 0; k < IDX_W; k++) begin
      a[k] = i[IDX_W-1-k];
    end
`else
    a = i;
`endif
    return a;
  endfunction

  // Sum of base-4 digits mod 4: the 2-bit adder truncation is the mod.
  function automatic logic [3:0] bank_onehot(input logic [IDX_W-1:0] a);
    logic [1:0] b;
    b = a[1:0] + a[3:2] + a[5:4] + a[7:6] + {1'b0, a[8]};
    return 4'b0001 << b;
  endfunction

  // Inputs never exceed 4095 < 2q, so one conditional subtraction reduces fully.
  function automatic logic [DATA_W-1:0] reduce_q(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    if (d >= Q_VAL) begin
      r = d - Q_VAL;
    end else begin
      r = d;
    end
    return r;
  endfunction

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              range_err_q, range_err_d;
  logic [3:0]        wen_q, wen_d;
  logic [ROW_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              in_ready_s;
  logic              busy_s;
  logic              done_s;
  logic              accept_s;
  logic [IDX_W-1:0]  eff_s;

  assign accept_s = bus.in_valid & in_ready_s;
  assign eff_s    = eff_index(idx_q);

  // State, index, sticky flag and write-port registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      range_err_q <= 1'b0;
      wen_q       <= 4'b0000;
      addr_q      <= {ROW_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      range_err_q <= range_err_d;
      wen_q       <= wen_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Next-state logic: FSM transitions, index counter and range flag.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    range_err_d = range_err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_LOAD;
          idx_d       = {IDX_W{1'b0}};
          range_err_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          idx_d = idx_q + 9'd1;
          if (bus.in_data >= Q_VAL) begin
            range_err_d = 1'b1;
          end else begin
            range_err_d = range_err_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Write-port next values; enable falls to zero after any non-accept cycle,
  // address and data simply hold.
  always_comb begin
    wen_d   = 4'b0000;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept_s) begin
      wen_d   = bank_onehot(eff_s);
      addr_d  = eff_s[IDX_W-1:2];
      wdata_d = reduce_q(bus.in_data);
    end else begin
      wen_d = 4'b0000;
    end
  end

  // Output decode from the registered state.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_s = 1'b0;
      end
      ST_LOAD: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  assign bus.in_ready   = in_ready_s;
  assign bus.busy       = busy_s;
  assign bus.done       = done_s;
  assign bus.range_err  = range_err_q;
  assign bus.bank_wen   = wen_q;
  assign bus.bank_addr  = addr_q;
  assign bus.bank_wdata = wdata_q;

endmodule

// File: tb/tb_ntt_poly_loader.sv
// ---------------------------------------------------------------------------
// tb_ntt_poly_loader
// Scoreboard bench for ntt_poly_loader. The driver pushes the expected bank
// write for every beat it offers; a negedge monitor pops and compares each
// write the DUT issues. Expected placement is computed from base-4 digit sums.
// ---------------------------------------------------------------------------
module tb_ntt_poly_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ntt_poly_loader_if bus ();

  ntt_poly_loader dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  wen;
    logic [6:0]  addr;
    logic [11:0] data;
    logic        last;
    logic        rerr;
  } wr_t;

  wr_t exp_q[$];
  wr_t obs_q[$];
  wr_t mon_e;
  wr_t mon_o;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int dmode    = 0;
  logic m_rerr = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int ref_eff(input int i);
    int r;
    r = i;
`ifdef LOAD_BITREV_EN
    r = 0;
    for (int k = 0; k < 9; k++) begin
      if (((i >> k) & 1) != 0) r += (1 << (8 - k));
    end
`endif
    return r;
  endfunction

  function automatic int ref_bank(input int a);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += (a >> (2 * k)) % 4;
    s += a / 256;
    return s % 4;
  endfunction

  function automatic int gen_data(input int i);
    int d;
    case (dmode)
      0: d = i;
      1: d = $urandom_range(0, 4095);
      2: d = (i == 0) ? 3329 : ((i == 1) ? 4095 : $urandom_range(0, 3328));
      default: d = i;
    endcase
    return d;
  endfunction

  // Monitor: compare every issued write against the scoreboard head.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.done === 1'b1) done_cnt++;
      if (bus.bank_wen !== 4'b0000) begin
        mon_o.wen  = bus.bank_wen;
        mon_o.addr = bus.bank_addr;
        mon_o.data = bus.bank_wdata;
        mon_o.last = bus.done;
        mon_o.rerr = bus.range_err;
        obs_q.push_back(mon_o);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_wen",   mon_o.wen,  mon_e.wen);
          chk("wr_addr",  mon_o.addr, mon_e.addr);
          chk("wr_data",  mon_o.data, mon_e.data);
          chk("wr_done",  mon_o.last, mon_e.last);
          chk("wr_rerr",  mon_o.rerr, mon_e.rerr);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    m_rerr   = 1'b0;
    done_cnt = 0;
    obs_q.delete();
    chk("ready_after_start", bus.in_ready, 1);
    chk("busy_after_start", bus.busy, 1);
    chk("rerr_cleared_by_start", bus.range_err, 0);
  endtask

  // vmode 0: valid always high, 1: random bubbles, 2: pattern 1,0,0,1 then high.
  task automatic stream(input int vmode, input int start_at, input int n);
    int   i;
    int   cyc;
    int   d;
    int   a;
    logic v;
    wr_t  e;
    i   = 0;
    cyc = 0;
    while (i < n) begin
      case (vmode)
        0: v = 1'b1;
        1: v = ($urandom_range(0, 3) != 0);
        2: v = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
        default: v = 1'b1;
      endcase
      bus.start = (i == start_at) && v;
      if (v) begin
        d = gen_data(i);
        a = ref_eff(i);
        if (d >= 3329) m_rerr = 1'b1;
        e.wen  = 4'(1 << ref_bank(a));
        e.addr = 7'(a / 4);
        e.data = 12'((d >= 3329) ? d - 3329 : d);
        e.last = (i == 511);
        e.rerr = m_rerr;
        exp_q.push_back(e);
        bus.in_data = 12'(d);
        i++;
      end else begin
        bus.in_data = 12'($urandom_range(0, 4095));
      end
      bus.in_valid = v;
      tick();
      cyc++;
      if (vmode == 2 && cyc == 4) chk("stall_two_writes", obs_q.size(), 2);
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic finish_check();
    chk("done_with_last", bus.done, 1);
    chk("busy_in_done", bus.busy, 1);
    chk("ready_low_in_done", bus.in_ready, 0);
    chk("write_count", obs_q.size(), 512);
    tick();
    chk("done_one_cycle", bus.done, 0);
    chk("busy_dropped", bus.busy, 0);
    chk("done_pulses", done_cnt, 1);
    chk("rerr_after_done", bus.range_err, m_rerr);
  endtask

  initial begin
    rst          = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 12'd0;
    #2;
    chk("rst_wen", bus.bank_wen, 0);
    chk("rst_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rerr", bus.range_err, 0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("idle_ready", bus.in_ready, 0);

    // Load 1: in_data = idx, valid held high.
    do_start();
    dmode = 0;
    stream(0, -1, 512);
    finish_check();
`ifdef LOAD_BITREV_EN
    chk("br_idx1_wen", obs_q[1].wen, 4'b0010);
    chk("br_idx1_row", obs_q[1].addr, 64);
    chk("br_idx2_wen", obs_q[2].wen, 4'b0100);
    chk("br_idx2_row", obs_q[2].addr, 32);
`else
    chk("idx0_wen", obs_q[0].wen, 4'b0001);
    chk("idx0_row", obs_q[0].addr, 0);
    chk("idx5_wen", obs_q[5].wen, 4'b0100);
    chk("idx5_row", obs_q[5].addr, 1);
    chk("idx511_wen", obs_q[511].wen, 4'b0010);
    chk("idx511_row", obs_q[511].addr, 127);
`endif
    chk("load1_rerr", bus.range_err, 0);

    // Load 2: out-of-range values at idx 0 and 1, random bubbles.
    do_start();
    dmode = 2;
    stream(1, -1, 512);
    finish_check();
    chk("reduce_3329", obs_q[0].data, 0);
    chk("reduce_4095", obs_q[1].data, 766);
    chk("rerr_sticky", bus.range_err, 1);

    // Load 3: stall pattern and a start pulse at idx 100.
    do_start();
    dmode = 1;
    stream(2, 100, 512);
    finish_check();

    // Load 4: reset asserted mid-load at idx 200.
    do_start();
    dmode = 1;
    stream(1, -1, 200);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_wen", bus.bank_wen, 0);
    chk("mid_rst_addr", bus.bank_addr, 0);
    chk("mid_rst_data", bus.bank_wdata, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_rerr", bus.range_err, 0);
    chk("mid_rst_pending", exp_q.size(), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_ready", bus.in_ready, 0);
    chk("post_rst_wen", bus.bank_wen, 0);
    chk("post_rst_busy", bus.busy, 0);

    // Load 5: fresh load restarts at index 0.
    do_start();
    dmode = 0;
    stream(0, -1, 512);
    finish_check();
    chk("restart_idx0_wen", obs_q[0].wen, 4'b0001);
    chk("restart_idx0_row", obs_q[0].addr, 0);

    tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
